dbus_uncached_ctrl: RTL and testbench
=====================================

Name: dbus_uncached_ctrl

Overview:
- Sequences the uncached data bus between the memory stage and the uncached bus master.
- Uncached stores are posted into a DEPTH-entry write buffer and retire without waiting for the bus.
- Uncached loads stall until every buffered store has drained, then issue one read, which gives strong MMIO ordering.
- Sits directly behind the memory-stage dbus mux, on its uncached port.

Parameters:
DEPTH, 4, write-buffer entries; power of two, ≥2
ADDR_W, 32, byte address width; bits [1:0] are forced to 0 downstream

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
req_read  in  1  uncached load request, held until stall=0
req_write  in  1  uncached store request, held until stall=0
req_address  in  ADDR_W  word-aligned physical address
req_wrdata  in  32  store data
req_byteenable  in  4  store byte lanes
stall  out  1  request not completed this cycle
rddata  out  32  load data, valid in the cycle where stall=0 for a read
bus_read  out  1  downstream read request
bus_write  out  1  downstream write request
bus_address  out  ADDR_W  downstream address
bus_wrdata  out  32  downstream write data
bus_byteenable  out  4  downstream byte lanes
bus_stall  in  1  downstream not accepted; transfer completes in a cycle with request=1 and bus_stall=0
bus_rddata  in  32  read data, valid in the read-completion cycle
wb_empty  out  1  write buffer empty and no read in progress (used by SYNC)

Behaviour:
- Reset (async, rst_n=0):
  - FIFO count=0, read/write pointers=0, state=IDLE, captured rddata=0.
  - bus_read=bus_write=0 and stall=0 immediately.
  - wb_empty=1.
  - Entries and in-flight transfers are dropped; reset mid-transfer is legal.
- FIFO entry: {addr[ADDR_W-1:2], wrdata, byteenable}. Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Push: state=IDLE & req_write & count<DEPTH.
  - stall=0 that cycle (combinational from registered count).
  - If count==DEPTH, stall=1; a pop in the same cycle does not free the slot until the next cycle.
- Pop: bus_write & ~bus_stall.
  - A push and a pop in the same cycle leave count unchanged.
- bus_write = (count≠0) & state≠RESP.
  - Drive head entry; byteenable=0 entries are still issued.
  - Head is stable until popped, so the request is held stable while bus_stall=1.
- FSM uc_state_t:
  - IDLE:
    - req_read → RD, with stall=1.
    - req_write → push rule.
    - No request → stall=0.
  - RD:
    - stall=1; FIFO continues draining.
    - When count==0, bus_read=1 and bus_address=req_address.
    - On bus_read & ~bus_stall, capture bus_rddata and go to RESP.
  - RESP:
    - stall=0, rddata=captured value, no bus request.
    - Next state IDLE.
- bus_read and bus_write are never both 1.
- bus_address = head address when bus_write, req_address when bus_read, else 0.
- Load latency with empty buffer and zero-wait bus is 3 cycles (IDLE, RD, RESP).
- Upstream requests are not aborted once accepted; squashing happens upstream.
- req_read & req_write together is illegal; a bench assertion flags it, and the RTL treats it as a read.
- rddata holds its last captured value outside RESP.
- wb_empty = (count==0) & state==IDLE.

Decomposition:
- cpu_defs package gets:
  - uncached_wbuf_entry_t (addr, wrdata, byteenable).
  - uc_state_t enum {IDLE, RD, RESP}.
  - `UNCACHED_WBUF_DEPTH` default constant.
- One sub-module, uncached_wbuf_fifo:
  - Synchronous FIFO of uncached_wbuf_entry_t with push/pop/full/empty/count and async active-low reset.
- The FSM and bus muxing stay in dbus_uncached_ctrl.

Test Plan:
- Single store 0x1FD0_F000, data 0xDEADBEEF, be=0xF, bus_stall=0 → stall=0 in the request cycle; next cycle bus_write=1 with the same address, data and be; then wb_empty=1.
- Five back-to-back stores with DEPTH=4 and bus_stall held 1 → first four accepted with stall=0, fifth stalls. Release bus_stall → fifth accepted one cycle after the first pop. Bus order is strictly FIFO.
- Three buffered stores, then a load from 0x1FD0_F004 with bus_rddata=0x12345678 → bus_read asserted only after the third write pops. The load returns 0x12345678 with stall=0 exactly one cycle after read completion.
- Load with empty buffer and bus_stall=1 for 3 cycles → bus_read and address held stable for 4 cycles; upstream stall=0 on cycle 6; bus_read and bus_write never overlap.
- rst_n asserted mid-read with two entries buffered → outputs go to reset values asynchronously; after release, no stale write or read is issued.
- Load immediately followed by a store (back-to-back) → the store is pushed in the IDLE cycle after RESP. Random bus_stall soak → bus transaction sequence equals program order, checked by scoreboard.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared core definitions for the uncached data-bus path.
// Holds the write-buffer entry layout and controller state encoding.
`ifndef UNCACHED_WBUF_DEPTH
`define UNCACHED_WBUF_DEPTH 4
`endif

package cpu_defs;

  localparam int UC_ADDR_W     = 32;
  localparam int UC_WBUF_DEPTH = `UNCACHED_WBUF_DEPTH;

  typedef struct packed {
    logic [UC_ADDR_W-3:0] addr;
    logic [31:0]          wrdata;
    logic [3:0]           byteenable;
  } uncached_wbuf_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    RESP
  } uc_state_t;

endpackage

// File: rtl/uncached_wbuf_fifo.sv
// Posted-store buffer for uncached writes.
// Plain synchronous FIFO; head entry stays put until popped.
module uncached_wbuf_fifo
  import cpu_defs::*;
#(
  parameter  int DEPTH = UC_WBUF_DEPTH,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push,
  input  uncached_wbuf_entry_t i_din,
  input  logic                 i_pop,
  output uncached_wbuf_entry_t o_head,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [PW:0]          o_count
);

  uncached_wbuf_entry_t r_mem [DEPTH];
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [PW:0]          r_count;
  logic                 w_push;
  logic                 w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + (PW+1)'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - (PW+1)'(1);
    end
  end

  // Storage needs no reset: a zero count marks every slot invalid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/dbus_uncached_ctrl.sv
// Uncached dbus sequencer: posted stores, loads ordered behind
// the store buffer so MMIO side effects happen in program order.
module dbus_uncached_ctrl
  import cpu_defs::*;
#(
  parameter  int DEPTH  = UC_WBUF_DEPTH,
  parameter  int ADDR_W = UC_ADDR_W,
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [31:0]       req_wrdata,
  input  logic [3:0]        req_byteenable,
  output logic              stall,
  output logic [31:0]       rddata,
  output logic              bus_read,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_address,
  output logic [31:0]       bus_wrdata,
  output logic [3:0]        bus_byteenable,
  input  logic              bus_stall,
  input  logic [31:0]       bus_rddata,
  output logic              wb_empty
);

  uc_state_t            r_state;
  uc_state_t            w_next;
  logic [31:0]          r_rddata;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_rd_done;
  logic                 w_full;
  logic                 w_empty;
  logic [PW:0]          w_count;
  uncached_wbuf_entry_t w_din;
  uncached_wbuf_entry_t w_head;

  assign w_din.addr       = req_address[ADDR_W-1:2];
  assign w_din.wrdata     = req_wrdata;
  assign w_din.byteenable = req_byteenable;

  uncached_wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_wbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // The RESP cycle keeps the bus quiet so the load result is isolated.
  assign bus_write = ~w_empty & (r_state != RESP);
  assign w_pop     = bus_write & ~bus_stall;
  assign wb_empty  = (w_count == '0) & (r_state == IDLE);
  assign rddata    = r_rddata;

  always_comb begin
    bus_address    = '0;
    bus_wrdata     = '0;
    bus_byteenable = '0;
    if (bus_write) begin
      bus_address    = {w_head.addr, 2'b00};
      bus_wrdata     = w_head.wrdata;
      bus_byteenable = w_head.byteenable;
    end else if (bus_read) begin
      bus_address = req_address;
    end
  end

  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    bus_read  = 1'b0;
    w_push    = 1'b0;
    w_rd_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_read) begin
          w_next = RD;
          stall  = 1'b1;
        end else if (req_write) begin
          if (w_full) stall  = 1'b1;
          else        w_push = 1'b1;
        end
      end
      RD: begin
        stall = 1'b1;
        if (w_empty) begin
          bus_read = 1'b1;
          if (!bus_stall) begin
            w_rd_done = 1'b1;
            w_next    = RESP;
          end
        end
      end
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rddata <= '0;
    end else begin
      r_state <= w_next;
      if (w_rd_done) r_rddata <= bus_rddata;
    end
  end

endmodule

// File: tb/tb_dbus_uncached_ctrl.sv
// Directed and scoreboarded bench for dbus_uncached_ctrl.
module tb_dbus_uncached_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_read, req_write;
  logic [31:0] req_address, req_wrdata;
  logic [3:0]  req_byteenable;
  logic        stall;
  logic [31:0] rddata;
  logic        bus_read, bus_write;
  logic [31:0] bus_address, bus_wrdata;
  logic [3:0]  bus_byteenable;
  logic        bus_stall;
  logic [31:0] bus_rddata;
  logic        wb_empty;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dbus_uncached_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_read       (req_read),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_wrdata     (req_wrdata),
    .req_byteenable (req_byteenable),
    .stall          (stall),
    .rddata         (rddata),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_address    (bus_address),
    .bus_wrdata     (bus_wrdata),
    .bus_byteenable (bus_byteenable),
    .bus_stall      (bus_stall),
    .bus_rddata     (bus_rddata),
    .wb_empty       (wb_empty)
  );

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } txn_t;

  txn_t log_q[$];
  txn_t exp_q[$];

  // Completed bus transfers, sampled mid-cycle when inputs are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (bus_read && bus_write) begin
        n_err++;
        $display("FAIL overlap: bus_read=%b bus_write=%b want not both",
                 bus_read, bus_write);
      end
      if ((bus_read || bus_write) && !bus_stall) begin
        if (bus_read)
          log_q.push_back('{1'b1, bus_address, bus_rddata, 4'h0});
        else
          log_q.push_back('{1'b0, bus_address, bus_wrdata,
                            bus_byteenable});
      end
      if (req_read && req_write)
        $error("illegal: req_read and req_write together");
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    req_read       = 1'b0;
    req_write      = 1'b0;
    req_address    = '0;
    req_wrdata     = '0;
    req_byteenable = '0;
  endtask

  task automatic drive_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    req_read       = 1'b0;
    req_write      = 1'b1;
    req_address    = a;
    req_wrdata     = d;
    req_byteenable = be;
  endtask

  task automatic drive_rd(input logic [31:0] a);
    req_read    = 1'b1;
    req_write   = 1'b0;
    req_address = a;
  endtask

  task automatic cmp_log(input string nm);
    int n;
    chk({nm, "_len"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_rd%0d", nm, i), 32'(log_q[i].rd),
          32'(exp_q[i].rd));
      chk($sformatf("%s_addr%0d", nm, i), log_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s_data%0d", nm, i), log_q[i].data, exp_q[i].data);
      chk($sformatf("%s_be%0d", nm, i), 32'(log_q[i].be),
          32'(exp_q[i].be));
    end
  endtask

  task automatic drain(input string nm, input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      cyc();
      bus_stall = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (wb_empty) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_drain_timeout"}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    bit          rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    bit          bs;
    logic [31:0] brd;
    bit          e_stall, e_br, e_bw;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    bit          e_wbe;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt[15];

  localparam logic [31:0] A0 = 32'h1FD0_F000;
  localparam logic [31:0] A4 = 32'h1FD0_F004;
  localparam logic [31:0] A8 = 32'h1FD0_F008;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  initial begin
    // rd wr addr wdata be bs brd | stall br bw addr wdata be wbe rdata
    vt[0]  = '{0,0,0,0,0,0,0,              0,0,0,0,0,0,1,0};
    vt[1]  = '{0,1,A0,32'hDEADBEEF,4'hF,0,0, 0,0,0,0,0,0,1,0};
    vt[2]  = '{0,0,0,0,0,0,0,  0,0,1,A0,32'hDEADBEEF,4'hF,0,0};
    vt[3]  = '{0,0,0,0,0,0,0,              0,0,0,0,0,0,1,0};
    vt[4]  = '{1,0,A4,0,0,0,32'hCAFEF00D,  1,0,0,0,0,0,1,0};
    vt[5]  = '{1,0,A4,0,0,0,32'hCAFEF00D,  1,1,0,A4,0,0,0,0};
    vt[6]  = '{1,0,A4,0,0,0,32'h0,  0,0,0,0,0,0,0,32'hCAFEF00D};
    vt[7]  = '{0,0,0,0,0,0,0,       0,0,0,0,0,0,1,32'hCAFEF00D};
    vt[8]  = '{1,0,A8,0,0,1,32'h0BADF00D,
               1,0,0,0,0,0,1,32'hCAFEF00D};
    vt[9]  = '{1,0,A8,0,0,1,32'h0BADF00D,
               1,1,0,A8,0,0,0,32'hCAFEF00D};
    vt[10] = '{1,0,A8,0,0,1,32'h0BADF00D,
               1,1,0,A8,0,0,0,32'hCAFEF00D};
    vt[11] = '{1,0,A8,0,0,1,32'h0BADF00D,
               1,1,0,A8,0,0,0,32'hCAFEF00D};
    vt[12] = '{1,0,A8,0,0,0,32'h0BADF00D,
               1,1,0,A8,0,0,0,32'hCAFEF00D};
    vt[13] = '{1,0,A8,0,0,0,32'h0,  0,0,0,0,0,0,0,32'h0BADF00D};
    vt[14] = '{0,0,0,0,0,0,0,       0,0,0,0,0,0,1,32'h0BADF00D};

    rst_n      = 1'b0;
    bus_stall  = 1'b0;
    bus_rddata = '0;
    idle_req();
    @(negedge clk);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_bus_write", 32'(bus_write), 0);
    chk("rst_bus_read", 32'(bus_read), 0);
    chk("rst_wb_empty", 32'(wb_empty), 1);
    chk("rst_rddata", rddata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: single store, zero-wait load, stalled load.
    foreach (vt[i]) begin
      cyc();
      req_read       = vt[i].rd;
      req_write      = vt[i].wr;
      req_address    = vt[i].addr;
      req_wrdata     = vt[i].wdata;
      req_byteenable = vt[i].be;
      bus_stall      = vt[i].bs;
      bus_rddata     = vt[i].brd;
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vt[i].e_stall));
      chk($sformatf("v%0d_bus_read", i), 32'(bus_read), 32'(vt[i].e_br));
      chk($sformatf("v%0d_bus_write", i), 32'(bus_write),
          32'(vt[i].e_bw));
      chk($sformatf("v%0d_bus_addr", i), bus_address, vt[i].e_addr);
      chk($sformatf("v%0d_bus_wrdata", i), bus_wrdata, vt[i].e_wdata);
      chk($sformatf("v%0d_bus_be", i), 32'(bus_byteenable),
          32'(vt[i].e_be));
      chk($sformatf("v%0d_wb_empty", i), 32'(wb_empty), 32'(vt[i].e_wbe));
      chk($sformatf("v%0d_rddata", i), rddata, vt[i].e_rdata);
    end

    // Fill the buffer behind a stalled bus; fifth store must wait.
    cyc();
    idle_req();
    log_q.delete();
    exp_q.delete();
    for (int i = 0; i < 5; i++)
      exp_q.push_back('{1'b0, A0 + 32'(16 * i), 32'h1000 + 32'(i),
                        4'(i + 1)});
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive_wr(exp_q[i].addr, exp_q[i].data, exp_q[i].be);
      bus_stall = 1'b1;
      @(negedge clk);
      chk($sformatf("fill%0d_stall", i), 32'(stall), 0);
    end
    cyc();
    drive_wr(exp_q[4].addr, exp_q[4].data, exp_q[4].be);
    @(negedge clk);
    chk("full_stall", 32'(stall), 1);
    chk("full_bus_write", 32'(bus_write), 1);
    chk("full_head_addr", bus_address, exp_q[0].addr);
    cyc();
    @(negedge clk);
    chk("full_stall2", 32'(stall), 1);
    chk("full_head_hold", bus_address, exp_q[0].addr);
    cyc();
    bus_stall = 1'b0;
    @(negedge clk);
    chk("pop_cycle_stall", 32'(stall), 1);
    cyc();
    bus_stall = 1'b1;
    @(negedge clk);
    chk("after_pop_stall", 32'(stall), 0);
    chk("after_pop_head", bus_address, exp_q[1].addr);
    cyc();
    idle_req();
    drain("fifo", 1'b0);
    cmp_log("fifo_order");

    // Load ordered behind three buffered stores.
    cyc();
    log_q.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++)
      exp_q.push_back('{1'b0, 32'h1FD0_E000 + 32'(4 * i),
                        32'hA0 + 32'(i), 4'hF});
    exp_q.push_back('{1'b1, A4, 32'h12345678, 4'h0});
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive_wr(exp_q[i].addr, exp_q[i].data, exp_q[i].be);
      bus_stall = 1'b1;
      @(negedge clk);
      chk($sformatf("ord_st%0d_stall", i), 32'(stall), 0);
    end
    cyc();
    drive_rd(A4);
    bus_rddata = 32'h12345678;
    @(negedge clk);
    chk("ord_ld_stall", 32'(stall), 1);
    cyc();
    bus_stall = 1'b0;
    begin
      bit seen;
      int nw;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus_read) begin
          nw = 0;
          foreach (log_q[j]) if (!log_q[j].rd) nw++;
          chk("ord_writes_before_read", 32'(nw), 3);
          seen = 1'b1;
          break;
        end
        chk("ord_wait_stall", 32'(stall), 1);
        cyc();
      end
      chk("ord_read_timeout", 32'(seen), 1);
    end
    cyc();
    @(negedge clk);
    chk("ord_resp_stall", 32'(stall), 0);
    chk("ord_resp_rddata", rddata, 32'h12345678);
    cyc();
    idle_req();
    @(negedge clk);
    cmp_log("ord_seq");

    // Asynchronous reset while a read waits behind two stores.
    for (int i = 0; i < 2; i++) begin
      cyc();
      drive_wr(32'h1FD0_D000 + 32'(4 * i), 32'h77 + 32'(i), 4'h3);
      bus_stall = 1'b1;
    end
    cyc();
    drive_rd(32'h1FD0_D100);
    cyc();
    @(negedge clk);
    chk("mid_rd_stall", 32'(stall), 1);
    chk("mid_rd_bus_write", 32'(bus_write), 1);
    #2;
    rst_n = 1'b0;
    idle_req();
    #1;
    chk("arst_stall", 32'(stall), 0);
    chk("arst_bus_write", 32'(bus_write), 0);
    chk("arst_bus_read", 32'(bus_read), 0);
    chk("arst_wb_empty", 32'(wb_empty), 1);
    chk("arst_rddata", rddata, 0);
    cyc();
    rst_n = 1'b1;
    bus_stall = 1'b0;
    log_q.delete();
    for (int k = 0; k < 6; k++) cyc();
    chk("arst_no_stale_txn", 32'(log_q.size()), 0);
    chk("arst_wb_empty_after", 32'(wb_empty), 1);

    // Load immediately followed by a store.
    cyc();
    drive_rd(32'h1FD0_F00C);
    bus_rddata = 32'h55AA55AA;
    @(negedge clk);
    chk("b2b_ld_stall", 32'(stall), 1);
    cyc();
    @(negedge clk);
    chk("b2b_rd_bus_read", 32'(bus_read), 1);
    cyc();
    @(negedge clk);
    chk("b2b_resp_stall", 32'(stall), 0);
    chk("b2b_resp_rddata", rddata, 32'h55AA55AA);
    cyc();
    drive_wr(32'h1FD0_F010, 32'h01020304, 4'h3);
    @(negedge clk);
    chk("b2b_st_stall", 32'(stall), 0);
    cyc();
    idle_req();
    @(negedge clk);
    chk("b2b_st_bus_write", 32'(bus_write), 1);
    chk("b2b_st_addr", bus_address, 32'h1FD0_F010);
    chk("b2b_st_data", bus_wrdata, 32'h01020304);

    // Random bus_stall soak against a program-order scoreboard.
    cyc();
    log_q.delete();
    exp_q.delete();
    for (int op = 0; op < 40; op++) begin
      txn_t t;
      bit done;
      t.rd   = ($urandom_range(0, 2) == 0);
      t.addr = 32'h1FD0_0000 | (32'($urandom_range(0, 255)) << 2);
      t.data = t.rd ? (t.addr ^ KEY) : $urandom;
      t.be   = t.rd ? 4'h0 : 4'($urandom_range(0, 15));
      exp_q.push_back(t);
      done = 1'b0;
      for (int k = 0; k < 100; k++) begin
        cyc();
        if (t.rd) drive_rd(t.addr);
        else      drive_wr(t.addr, t.data, t.be);
        bus_rddata = t.addr ^ KEY;
        bus_stall  = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (!stall) begin
          if (t.rd) chk($sformatf("soak_ld%0d", op), rddata, t.data);
          done = 1'b1;
          break;
        end
      end
      chk($sformatf("soak_op%0d_timeout", op), 32'(done), 1);
    end
    cyc();
    idle_req();
    drain("soak", 1'b1);
    cmp_log("soak_seq");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
